// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM family.
//   rdw_mode_e   : what a read returns when it hits the address being written
//   init_state_e : states of the clear-after-reset sequencer
//   bytes_of()   : number of byte lanes in a word of the given width
package ram_pkg;

  typedef enum logic {
    RDW_OLD,
    RDW_NEW
  } rdw_mode_e;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Clear-after-reset sequencer. After rst deasserts it walks every address
// once, issuing a write strobe per cycle, then parks in READY until the next
// rst. With CLEAR_ON_RESET=0 it is held in READY and never strobes.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset, restarts the sweep at 0
//   init_busy_o  high while the sweep is running
//   init_we_o    write strobe for the zero-fill
//   init_addr_o  address being cleared this cycle
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  init_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      if (CLEAR_ON_RESET) begin
        state_q <= INIT;
        busy_q  <= 1'b1;
      end else begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        INIT: begin
          // The last address is the terminal count: stop here rather than
          // letting the counter roll over to 0.
          if (cnt_q == LAST_ADDR) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_busy_o = busy_q;
  assign init_we_o   = busy_q;
  assign init_addr_o = cnt_q;

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port synchronous RAM with byte-enable writes, one write and one
// read port on a single clock, read latency of 1 or 2 cycles, selectable
// read-during-write behaviour and an optional zero-fill after reset.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   we, wr_addr, be, din  write request, address, byte enables, data
//   re, rd_addr         read request and address
//   dout, dout_valid    read data (held between reads) and one-cycle valid
//   init_busy           zero-fill in progress; we/re are ignored meanwhile
module sdp_ram_be
  import ram_pkg::*;
#(
  parameter int        ADDR_WIDTH     = 4,
  parameter int        DATA_WIDTH     = 32,
  parameter int        READ_LATENCY   = 1,
  parameter rdw_mode_e RDW_MODE       = RDW_OLD,
  parameter bit        CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [bytes_of(DATA_WIDTH)-1:0]  be,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  output logic                             init_busy
);

  localparam int NUM_BYTES = bytes_of(DATA_WIDTH);
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sdp_ram_be: READ_LATENCY must be 1 or 2");
  end

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  ram_init_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_seq (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_busy_o (init_busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  logic acc_we;
  logic acc_re;
  assign acc_we = we & ~init_busy;
  assign acc_re = re & ~init_busy;

  // Zero-fill owns the write port while it runs.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [NUM_BYTES-1:0]  mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  assign mem_we    = init_we | acc_we;
  assign mem_waddr = init_we ? init_addr : wr_addr;
  assign mem_be    = init_we ? '1 : be;
  assign mem_wdata = init_we ? '0 : din;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // ---- stage p0: array read and collision bypass ----
  logic [DATA_WIDTH-1:0] old_word_p0;
  logic [DATA_WIDTH-1:0] merged_p0;
  logic                  collide_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;

  always_comb begin
    old_word_p0 = mem[rd_addr];
    merged_p0   = old_word_p0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) merged_p0[8*i +: 8] = din[8*i +: 8];
    end
    collide_p0 = acc_we & acc_re & (wr_addr == rd_addr);
    rd_word_p0 = (RDW_MODE == RDW_NEW && collide_p0) ? merged_p0 : old_word_p0;
  end

  // ---- stage p1: first read register ----
  logic [DATA_WIDTH-1:0] data_p1_q;
  logic                  vld_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else begin
      vld_p1_q <= acc_re;
      if (acc_re) data_p1_q <= rd_word_p0;
    end
  end

  // ---- stage p2: optional output register ----
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] data_p2_q;
    logic                  vld_p2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) data_p2_q <= data_p1_q;
      end
    end

    assign dout       = data_p2_q;
    assign dout_valid = vld_p2_q;
  end else begin : g_lat1
    assign dout       = data_p1_q;
    assign dout_valid = vld_p1_q;
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Two instances share one stimulus stream:
//   dut_a : READ_LATENCY=1, RDW_OLD
//   dut_b : READ_LATENCY=2, RDW_NEW
module tb_sdp_ram_be;
  import ram_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  wr_addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic        re;
  logic [3:0]  rd_addr;

  logic [31:0] dout_a, dout_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  sdp_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1),
    .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .be(be), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout_a), .dout_valid(valid_a),
    .init_busy(busy_a)
  );

  sdp_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2),
    .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .be(be), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout_b), .dout_valid(valid_b),
    .init_busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory as a plain array; each accepted read is scheduled for delivery
  // on the edge numbered (accept edge + latency - 1).
  logic [31:0] m_mem [16];
  logic [31:0] sched_a [int];
  logic [31:0] sched_b [int];
  int          cyc       = 0;
  int          busy_left = 0;
  bit          started   = 0;
  logic [31:0] hold_a = '0, hold_b = '0;
  logic        ev_a = 1'b0, ev_b = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [31:0] old_w;
    cyc++;
    if (rst) begin
      started   = 1;
      busy_left = 16;
      sched_a.delete();
      sched_b.delete();
      hold_a = '0; hold_b = '0;
      ev_a = 1'b0; ev_b = 1'b0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = '0;
      end else begin
        if (re) begin
          old_w = m_mem[rd_addr];
          sched_a[cyc]     = old_w;
          sched_b[cyc + 1] = (we && wr_addr == rd_addr) ? merge(old_w, din, be) : old_w;
        end
        if (we) m_mem[wr_addr] = merge(m_mem[wr_addr], din, be);
      end
      ev_a = sched_a.exists(cyc);
      if (ev_a) begin hold_a = sched_a[cyc]; sched_a.delete(cyc); end
      ev_b = sched_b.exists(cyc);
      if (ev_b) begin hold_b = sched_b[cyc]; sched_b.delete(cyc); end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("model_busy_a", {31'b0, busy_a}, {31'b0, busy_left > 0});
      cmp("model_busy_b", {31'b0, busy_b}, {31'b0, busy_left > 0});
      cmp("model_vld_a", {31'b0, valid_a}, {31'b0, ev_a});
      cmp("model_vld_b", {31'b0, valid_b}, {31'b0, ev_b});
      cmp("model_dout_a", dout_a, hold_a);
      cmp("model_dout_b", dout_b, hold_b);
    end
  end

  int vcnt_a = 0, vcnt_b = 0;
  always @(negedge clk) begin
    if (valid_a === 1'b1) vcnt_a++;
    if (valid_b === 1'b1) vcnt_b++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] e);
    wr_addr = a; din = d; be = e; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    cmp({nm, "_vld_a"}, {31'b0, valid_a}, 32'd1);
    cmp({nm, "_a"}, dout_a, exp_a);
    tick();
    cmp({nm, "_vld_b"}, {31'b0, valid_b}, 32'd1);
    cmp({nm, "_b"}, dout_b, exp_b);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic        v_we [9] = '{1, 1, 1, 0, 1, 1, 0, 1, 0};
  logic [3:0]  v_wa [9] = '{2, 7, 7, 0, 9, 9, 0, 15, 0};
  logic [3:0]  v_be [9] = '{4'hF, 4'h3, 4'hC, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 4'h0};
  logic [31:0] v_d  [9] = '{32'h01020304, 32'hCAFEF00D, 32'h12345678, 32'h0,
                            32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000, 32'h0};
  logic        v_re [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [3:0]  v_ra [9] = '{0, 2, 7, 7, 9, 9, 9, 15, 15};

  initial begin
    int n;
    int va0, vb0;
    logic        s_va [6];
    logic [31:0] s_da [6];
    logic        s_vb [6];
    logic [31:0] s_db [6];

    rst = 1'b1; we = 1'b0; re = 1'b0;
    wr_addr = '0; rd_addr = '0; be = '0; din = '0;
    #1;

    // 1. clear after reset
    do_reset();
    wait_init(n);
    cmp("init_cycles", n, 32'd16);
    va0 = vcnt_a; vb0 = vcnt_b;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); re = 1'b1;
      tick();
    end
    re = 1'b0;
    tick();
    tick();
    cmp("clear_reads_a", vcnt_a - va0, 32'd16);
    cmp("clear_reads_b", vcnt_b - vb0, 32'd16);

    // 2. byte enables
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd_chk("byte_en", 4'd3, 32'hAA22CC44, 32'hAA22CC44);

    // 3. collision, full and partial byte enables
    wr_addr = 4'd5; rd_addr = 4'd5; din = 32'hDEADBEEF; be = 4'hF;
    we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    cmp("rdw_old_a", dout_a, 32'h00000000);
    tick();
    cmp("rdw_new_b", dout_b, 32'hDEADBEEF);
    rd_chk("after_rdw", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    wr_addr = 4'd5; rd_addr = 4'd5; din = 32'h11223344; be = 4'b0101;
    we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    cmp("rdw_part_old_a", dout_a, 32'hDEADBEEF);
    tick();
    cmp("rdw_part_new_b", dout_b, 32'hDE22BE44);
    rd_chk("after_part", 4'd5, 32'hDE22BE44, 32'hDE22BE44);

    // 4. latency and throughput
    for (int i = 0; i < 4; i++) wr(4'(i), 32'(i), 4'hF);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin rd_addr = 4'(k); re = 1'b1; end
      else re = 1'b0;
      tick();
      s_va[k] = valid_a; s_da[k] = dout_a;
      s_vb[k] = valid_b; s_db[k] = dout_b;
    end
    for (int k = 0; k < 6; k++) begin
      cmp($sformatf("thru_vld_a%0d", k), {31'b0, s_va[k]}, {31'b0, k < 4});
      cmp($sformatf("thru_vld_b%0d", k), {31'b0, s_vb[k]}, {31'b0, k >= 1 && k <= 4});
      if (k < 4) cmp($sformatf("thru_a%0d", k), s_da[k], 32'(k));
      if (k >= 1 && k <= 4) cmp($sformatf("thru_b%0d", k), s_db[k], 32'(k - 1));
    end

    // 5. requests during init are ignored
    do_reset();
    repeat (3) tick();
    va0 = vcnt_a; vb0 = vcnt_b;
    wr_addr = 4'd0; rd_addr = 4'd0; din = 32'hFFFFFFFF; be = 4'hF;
    we = 1'b1; re = 1'b1;
    repeat (5) tick();
    we = 1'b0; re = 1'b0;
    tick();
    tick();
    cmp("busy_no_vld_a", vcnt_a - va0, 32'd0);
    cmp("busy_no_vld_b", vcnt_b - vb0, 32'd0);
    wait_init(n);
    rd_chk("busy_no_write", 4'd0, 32'h0, 32'h0);

    // 6. reset mid-init restarts the sweep
    do_reset();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    cmp("mid_rst_busy", {31'b0, busy_a}, 32'd1);
    cmp("mid_rst_vld", {31'b0, valid_a}, 32'd0);
    tick();
    rst = 1'b0;
    wait_init(n);
    cmp("reinit_cycles", n, 32'd16);

    // 7. mixed concurrent traffic, checked by the model
    for (int k = 0; k < 9; k++) begin
      we = v_we[k]; wr_addr = v_wa[k]; be = v_be[k]; din = v_d[k];
      re = v_re[k]; rd_addr = v_ra[k];
      tick();
    end
    we = 1'b0; re = 1'b0;
    tick();
    tick();
    rd_chk("mixed_7", 4'd7, 32'h1234F00D, 32'h1234F00D);
    rd_chk("mixed_2", 4'd2, 32'h01020304, 32'h01020304);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
Simple dual-port synchronous RAM: one write port and one read port, both on a single clock. It is the parametrised successor to the single-port RAM, and adds:
- byte-enable writes
- concurrent read and write
- selectable read latency (1 or 2)
- selectable read-during-write collision mode
- an optional hardware clear-after-reset sequencer

It serves as the generic buffer store for FIFOs, line buffers and register-file-style storage in the memory chapter.

Parameters:
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8 (NUM_BYTES = DATA_WIDTH/8)
READ_LATENCY, 1, cycles from accepted read to dout; legal values 1 or 2
RDW_MODE, RDW_OLD, same-address collision result; RDW_OLD or RDW_NEW (enum from ram_pkg)
CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset; 0 = contents undefined, no init phase

Ports:
clk  in  1  clock, all activity on rising edge
rst  in  1  synchronous active-high reset
we  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
be  in  DATA_WIDTH/8  byte enables; bit i covers din[8i+7:8i]
din  in  DATA_WIDTH  write data
re  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
dout  out  DATA_WIDTH  read data
dout_valid  out  1  dout carries the result of a read accepted READ_LATENCY cycles earlier
init_busy  out  1  clear sequence in progress; requests ignored

Behaviour:
- Reset, when rst=1 at an edge:
  - dout=0, dout_valid=0, read pipeline valid bits cleared.
  - If CLEAR_ON_RESET=1: init_busy=1 and the init counter is set to 0. If CLEAR_ON_RESET=0: init_busy=0.
  - Memory contents are not touched by rst itself.
- Init FSM (CLEAR_ON_RESET=1), states INIT and READY:
  - INIT: each cycle, write all-zero to mem[cnt] and increment cnt.
  - When cnt == DEPTH-1 is written, go to READY; init_busy falls on the next edge.
  - Result: exactly DEPTH cycles of init_busy=1 after rst deasserts.
  - rst asserted mid-INIT restarts the sequence at address 0.
  - READY is terminal until the next rst.
  - With CLEAR_ON_RESET=0 the FSM is held in READY.
- Request gating: while init_busy=1, we and re are ignored. No memory write occurs and no dout_valid pulse is produced for these requests.
- Write (READY, we=1): for each i with be[i]=1, mem[wr_addr] byte i <= din byte i; other bytes keep their value. we=1 with be=0 is a no-op.
- Read (READY, re=1):
  - READ_LATENCY=1: the array is read into dout at the edge. dout and dout_valid=1 are visible in the cycle after the request.
  - READ_LATENCY=2: an additional output register is added; dout and dout_valid appear two cycles after the request.
  - Back-to-back reads give one result per cycle (full throughput).
  - dout holds its last value when no read completes; dout_valid is a one-cycle pulse per accepted read.
- Collision (we=1, re=1, wr_addr==rd_addr in the same cycle):
  - RDW_OLD: the read returns the pre-write word.
  - RDW_NEW: the read returns the merged word — din bytes where be=1, old bytes elsewhere (bypass mux).
  - The write always completes.
  - Different addresses: no interaction.
- Address wrap: addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case. The init counter is ADDR_WIDTH+1 bits or uses a terminal-count flag, so it never wraps silently.

Decomposition:
- ram_pkg:
  - typedef enum rdw_mode_e {RDW_OLD, RDW_NEW}
  - typedef enum init_state_e {INIT, READY}
  - function bytes_of(width) returning width/8
- The top module asserts at elaboration that DATA_WIDTH%8==0 and READ_LATENCY is 1 or 2.
- One natural sub-module: ram_init_seq. It contains the FSM, counter and init_busy, and outputs an init write strobe and init address that the top module muxes onto the write port.

Test Plan:
1. Clear after reset (CLEAR_ON_RESET=1, ADDR_WIDTH=4):
   - rst for 2 cycles, then release -> init_busy=1 for exactly 16 cycles.
   - Then read addresses 0..15 -> all dout=0x00000000, one dout_valid per read.
2. Byte enables:
   - Write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 to addr 3 with be=4'b0101.
   - Read addr 3 -> 0xAA22CC44.
3. Collision:
   - mem[5]=0x0; same cycle we=1, re=1, addr 5, din=0xDEADBEEF, be=4'b1111.
   - RDW_OLD -> dout=0x00000000; RDW_NEW -> dout=0xDEADBEEF.
   - Following read of addr 5 -> 0xDEADBEEF in both modes.
4. Latency and throughput, READ_LATENCY=2:
   - re on 4 consecutive cycles, addresses 0..3, holding 0,1,2,3.
   - dout_valid high for 4 cycles starting 2 cycles after the first re; dout sequence 0,1,2,3.
5. Requests during init:
   - Assert we=1 to addr 0 with 0xFFFFFFFF and re=1 while init_busy=1 -> no dout_valid pulse.
   - After init, addr 0 reads 0x00000000.
6. Reset mid-init:
   - Assert rst after 7 init cycles -> dout_valid=0, init_busy stays 1.
   - After release, init_busy lasts a full 16 cycles.
